lsu_unit: RTL and testbench

Load/store unit on the int2 issue slot. It consumes the registered memory operation from the execute buffer and handles one operation at a time. It drives `mem_issue_stall` back to the buffer while busy, talks to the data memory over a req/gnt/rvalid interface, and returns one writeback pulse per operation to the PRF/ROB. Loads issue speculatively. Stores issue only once they are at the ROB head. Flushes kill younger in-flight work.

---
 rtl/lsu_unit_pkg.sv | 41 ++++
 rtl/lsu_unit_if.sv | 23 ++
 rtl/lsu_unit_align.sv | 51 +++++
 rtl/lsu_unit.sv | 179 +++++++++++++++++
 tb/tb_lsu_unit.sv | 292 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/lsu_unit_pkg.sv
// Shared load/store definitions: widths, op control bundle, LSU states,
// funct3 encodings and the robid age compare used by all flush logic.
package lsu_unit_pkg;

    localparam int ROB_WIDTH = 4;
    localparam int PRF_WIDTH = 6;

    typedef struct packed {
        logic        mem_read;
        logic        mem_write;
        logic [2:0]  funct3;
        logic [31:0] imm;
    } control_type;

    typedef enum logic [2:0] {
        IDLE,
        WAIT_HEAD,
        REQ,
        RSP,
        DRAIN,
        WB,
        EXC
    } lsu_state_t;

    localparam logic [2:0] F3_LB  = 3'b000;
    localparam logic [2:0] F3_LH  = 3'b001;
    localparam logic [2:0] F3_LW  = 3'b010;
    localparam logic [2:0] F3_LBU = 3'b100;
    localparam logic [2:0] F3_LHU = 3'b101;
    localparam logic [2:0] F3_SB  = 3'b000;
    localparam logic [2:0] F3_SH  = 3'b001;
    localparam logic [2:0] F3_SW  = 3'b010;

    // The MSB is a wrap bit, so a differing MSB inverts the index compare.
    function automatic logic rob_younger(input logic [ROB_WIDTH:0] a,
                                         input logic [ROB_WIDTH:0] f);
        rob_younger = a[ROB_WIDTH] ^ f[ROB_WIDTH] ^
                      (a[ROB_WIDTH-1:0] > f[ROB_WIDTH-1:0]);
    endfunction

endpackage

// File: rtl/lsu_unit_if.sv
// Data memory req/gnt/rvalid bus between the LSU (master) and memory (slave).
interface lsu_unit_if;

    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_gnt;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    modport master (
        output dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        input  dmem_gnt, dmem_rvalid, dmem_rdata
    );

    modport slave (
        input  dmem_req, dmem_we, dmem_addr, dmem_wdata, dmem_be,
        output dmem_gnt, dmem_rvalid, dmem_rdata
    );

endinterface

// File: rtl/lsu_unit_align.sv
// Byte-lane steering: store enables/data, load extraction and misalignment
// detection from the low address bits and funct3.
module lsu_unit_align
    import lsu_unit_pkg::*;
(
    input  logic [1:0]  addr_lo,
    input  logic [2:0]  funct3,
    input  logic [31:0] rs2,
    input  logic [31:0] rdata,
    output logic [3:0]  be,
    output logic [31:0] wdata,
    output logic [31:0] load_data,
    output logic        misaligned
);

    logic [31:0] shifted;

    // Store encodings share funct3 values with the signed loads.
    always_comb begin
        shifted    = rdata >> {addr_lo, 3'b000};
        wdata      = rs2 << {addr_lo, 3'b000};
        be         = 4'b1111;
        load_data  = shifted;
        misaligned = 1'b0;
        case (funct3)
            F3_LB: begin
                be        = 4'b0001 << addr_lo;
                load_data = {{24{shifted[7]}}, shifted[7:0]};
            end
            F3_LH: begin
                be         = 4'b0011 << addr_lo;
                load_data  = {{16{shifted[15]}}, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            F3_LW: begin
                misaligned = (addr_lo != 2'b00);
            end
            F3_LBU: begin
                be        = 4'b0001 << addr_lo;
                load_data = {24'h000000, shifted[7:0]};
            end
            F3_LHU: begin
                be         = 4'b0011 << addr_lo;
                load_data  = {16'h0000, shifted[15:0]};
                misaligned = addr_lo[0];
            end
            default: ;
        endcase
    end

endmodule

// File: rtl/lsu_unit.sv
// Single-op load/store unit on int2: loads issue speculatively, stores wait
// for the ROB head, flushes kill younger work and drain orphaned responses.
module lsu_unit
    import lsu_unit_pkg::*;
(
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 flush_valid,
    input  logic [ROB_WIDTH:0]   flush_robid,
    input  logic [ROB_WIDTH:0]   rob_head_robid,
    input  logic                 int2_valid,
    input  logic [31:0]          int2_pc,
    input  control_type          int2_control,
    input  logic [31:0]          int2_rs1,
    input  logic [31:0]          int2_rs2,
    input  logic [PRF_WIDTH-1:0] int2_T,
    input  logic [ROB_WIDTH:0]   int2_robid,
    output logic                 mem_issue_stall,
    lsu_unit_if.master           dmem,
    output logic                 wb_valid,
    output logic                 wb_we,
    output logic [PRF_WIDTH-1:0] wb_T,
    output logic [31:0]          wb_data,
    output logic [ROB_WIDTH:0]   wb_robid,
    output logic                 wb_exc,
    output logic [31:0]          wb_pc
);

    lsu_state_t           state_q, state_d;
    logic [ROB_WIDTH:0]   robid_q, robid_d;
    logic [PRF_WIDTH-1:0] t_q, t_d;
    logic [31:0]          pc_q, pc_d;
    logic [2:0]           funct3_q, funct3_d;
    logic                 write_q, write_d;
    logic [31:0]          addr_q, addr_d;
    logic [31:0]          rs2_q, rs2_d;
    logic [31:0]          rdata_q, rdata_d;

    logic [31:0] new_addr;
    logic [1:0]  align_addr;
    logic [2:0]  align_f3;
    logic [3:0]  align_be;
    logic [31:0] align_wdata;
    logic [31:0] align_load;
    logic        align_misaligned;
    logic        kill;
    logic        req_active;
    logic        wb_active;

    lsu_unit_align u_align (
        .addr_lo    (align_addr),
        .funct3     (align_f3),
        .rs2        (rs2_q),
        .rdata      (dmem.dmem_rdata),
        .be         (align_be),
        .wdata      (align_wdata),
        .load_data  (align_load),
        .misaligned (align_misaligned)
    );

    // In IDLE the aligner checks the incoming op; otherwise it serves the captured one.
    always_comb begin
        new_addr   = int2_rs1 + int2_control.imm;
        align_addr = (state_q == IDLE) ? new_addr[1:0] : addr_q[1:0];
        align_f3   = (state_q == IDLE) ? int2_control.funct3 : funct3_q;
        kill       = flush_valid && rob_younger(robid_q, flush_robid);
    end

    always_comb begin
        state_d  = state_q;
        robid_d  = robid_q;
        t_d      = t_q;
        pc_d     = pc_q;
        funct3_d = funct3_q;
        write_d  = write_q;
        addr_d   = addr_q;
        rs2_d    = rs2_q;
        rdata_d  = rdata_q;
        case (state_q)
            IDLE: begin
                if (int2_valid && !flush_valid) begin
                    robid_d  = int2_robid;
                    t_d      = int2_T;
                    pc_d     = int2_pc;
                    funct3_d = int2_control.funct3;
                    write_d  = int2_control.mem_write && !int2_control.mem_read;
                    addr_d   = new_addr;
                    rs2_d    = int2_rs2;
                    if (align_misaligned)
                        state_d = EXC;
                    else if (write_d)
                        state_d = WAIT_HEAD;
                    else
                        state_d = REQ;
                end
            end
            WAIT_HEAD: begin
                if (kill)
                    state_d = IDLE;
                else if (rob_head_robid == robid_q)
                    state_d = REQ;
            end
            REQ: begin
                if (dmem.dmem_gnt) begin
                    if (write_q)
                        state_d = WB;
                    else
                        state_d = kill ? DRAIN : RSP;
                end else if (kill) begin
                    state_d = IDLE;
                end
            end
            RSP: begin
                if (dmem.dmem_rvalid) begin
                    rdata_d = align_load;
                    state_d = kill ? IDLE : WB;
                end else if (kill) begin
                    state_d = DRAIN;
                end
            end
            DRAIN: begin
                if (dmem.dmem_rvalid)
                    state_d = IDLE;
            end
            WB, EXC: begin
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset_n) begin
            state_q  <= IDLE;
            robid_q  <= '0;
            t_q      <= '0;
            pc_q     <= '0;
            funct3_q <= '0;
            write_q  <= 1'b0;
            addr_q   <= '0;
            rs2_q    <= '0;
            rdata_q  <= '0;
        end else begin
            state_q  <= state_d;
            robid_q  <= robid_d;
            t_q      <= t_d;
            pc_q     <= pc_d;
            funct3_q <= funct3_d;
            write_q  <= write_d;
            addr_q   <= addr_d;
            rs2_q    <= rs2_d;
            rdata_q  <= rdata_d;
        end
    end

    // A store in WB has already been granted at the head and is never killed.
    always_comb begin
        req_active = (state_q == REQ);
        wb_active  = ((state_q == WB) || (state_q == EXC)) &&
                     !(kill && !(state_q == WB && write_q));
    end

    assign mem_issue_stall = (state_q != IDLE);

    assign dmem.dmem_req   = req_active;
    assign dmem.dmem_we    = req_active && write_q;
    assign dmem.dmem_addr  = req_active ? {addr_q[31:2], 2'b00} : 32'h0;
    assign dmem.dmem_be    = req_active ? align_be : 4'h0;
    assign dmem.dmem_wdata = req_active ? align_wdata : 32'h0;

    assign wb_valid = wb_active;
    assign wb_we    = wb_active && (state_q == WB) && !write_q;
    assign wb_exc   = wb_active && (state_q == EXC);
    assign wb_T     = wb_active ? t_q : '0;
    assign wb_robid = wb_active ? robid_q : '0;
    assign wb_pc    = wb_active ? pc_q : 32'h0;
    assign wb_data  = wb_we ? rdata_q : 32'h0;

endmodule

// File: tb/tb_lsu_unit.sv
// Directed bench for lsu_unit: a vector table of single ops against a small
// memory responder, plus hand sequences for head wait, drain, wrap and reset.
module tb_lsu_unit;
    import lsu_unit_pkg::*;

    logic                 clk;
    logic                 reset_n;
    logic                 flush_valid;
    logic [ROB_WIDTH:0]   flush_robid;
    logic [ROB_WIDTH:0]   rob_head_robid;
    logic                 int2_valid;
    logic [31:0]          int2_pc;
    control_type          int2_control;
    logic [31:0]          int2_rs1;
    logic [31:0]          int2_rs2;
    logic [PRF_WIDTH-1:0] int2_T;
    logic [ROB_WIDTH:0]   int2_robid;
    logic                 mem_issue_stall;
    logic                 wb_valid;
    logic                 wb_we;
    logic [PRF_WIDTH-1:0] wb_T;
    logic [31:0]          wb_data;
    logic [ROB_WIDTH:0]   wb_robid;
    logic                 wb_exc;
    logic [31:0]          wb_pc;

    lsu_unit_if dmem_bus ();

    lsu_unit dut (
        .clk             (clk),
        .reset_n         (reset_n),
        .flush_valid     (flush_valid),
        .flush_robid     (flush_robid),
        .rob_head_robid  (rob_head_robid),
        .int2_valid      (int2_valid),
        .int2_pc         (int2_pc),
        .int2_control    (int2_control),
        .int2_rs1        (int2_rs1),
        .int2_rs2        (int2_rs2),
        .int2_T          (int2_T),
        .int2_robid      (int2_robid),
        .mem_issue_stall (mem_issue_stall),
        .dmem            (dmem_bus),
        .wb_valid        (wb_valid),
        .wb_we           (wb_we),
        .wb_T            (wb_T),
        .wb_data         (wb_data),
        .wb_robid        (wb_robid),
        .wb_exc          (wb_exc),
        .wb_pc           (wb_pc)
    );

    typedef struct {
        logic        is_write;
        logic [2:0]  funct3;
        logic [31:0] rs1;
        logic [31:0] imm;
        logic [31:0] rs2;
        logic [31:0] rdata;
        logic        exp_exc;
        logic [31:0] exp_addr;
        logic [3:0]  exp_be;
        logic [31:0] exp_wdata;
        logic [31:0] exp_data;
        int          exp_lat;
    } vec_t;

    vec_t vecs[11];
    int   total = 0;
    int   bad   = 0;
    int   wb_pulses = 0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk)
        if (reset_n && wb_valid) wb_pulses <= wb_pulses + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("[TB] FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
        end
    endtask

    // Drives one op at the current negedge; accepted on the following posedge.
    task automatic drive_op(input logic is_write, input logic [2:0] f3, input logic [31:0] rs1,
                            input logic [31:0] imm, input logic [31:0] rs2,
                            input logic [ROB_WIDTH:0] robid, input logic [PRF_WIDTH-1:0] t,
                            input logic [31:0] pc);
        int2_valid             = 1'b1;
        int2_control.mem_read  = !is_write;
        int2_control.mem_write = is_write;
        int2_control.funct3    = f3;
        int2_control.imm       = imm;
        int2_rs1               = rs1;
        int2_rs2               = rs2;
        int2_robid             = robid;
        int2_T                 = t;
        int2_pc                = pc;
        @(posedge clk);
        #1 int2_valid = 1'b0;
    endtask

    task automatic apply_stimulus(input vec_t v, input int idx);
        int   cycles;
        logic got_wb;
        logic saw_req;
        logic resp_pending;
        logic [ROB_WIDTH:0]   robid;
        logic [PRF_WIDTH-1:0] t;
        logic [31:0]          pc;
        robid          = (ROB_WIDTH+1)'(idx + 1);
        t              = PRF_WIDTH'(idx + 3);
        pc             = 32'h1000 + 32'(idx * 4);
        rob_head_robid = robid;
        drive_op(v.is_write, v.funct3, v.rs1, v.imm, v.rs2, robid, t, pc);
        cycles = 0; got_wb = 0; saw_req = 0; resp_pending = 0;
        while (!got_wb && cycles < 50) begin
            @(negedge clk);
            cycles++;
            dmem_bus.dmem_gnt    = 1'b0;
            dmem_bus.dmem_rvalid = 1'b0;
            if (dmem_bus.dmem_req) begin
                if (!saw_req) begin
                    check($sformatf("v%0d addr", idx), dmem_bus.dmem_addr, v.exp_addr);
                    check($sformatf("v%0d be", idx), 32'(dmem_bus.dmem_be), 32'(v.exp_be));
                    check($sformatf("v%0d wdata", idx), dmem_bus.dmem_wdata, v.exp_wdata);
                    check($sformatf("v%0d we", idx), 32'(dmem_bus.dmem_we), 32'(v.is_write));
                end
                saw_req = 1'b1;
                dmem_bus.dmem_gnt = 1'b1;
                resp_pending = !v.is_write;
            end else if (resp_pending) begin
                dmem_bus.dmem_rvalid = 1'b1;
                dmem_bus.dmem_rdata  = v.rdata;
                resp_pending = 1'b0;
            end
            if (wb_valid) begin
                got_wb = 1'b1;
                check_output(v, idx, cycles, saw_req, robid, t, pc);
            end
        end
        dmem_bus.dmem_gnt    = 1'b0;
        dmem_bus.dmem_rvalid = 1'b0;
        if (!got_wb) check($sformatf("v%0d wb_timeout", idx), 32'd0, 32'd1);
        @(negedge clk);
        check($sformatf("v%0d stall_after", idx), 32'(mem_issue_stall), 32'd0);
        check($sformatf("v%0d single_wb", idx), 32'(wb_valid), 32'd0);
    endtask

    task automatic check_output(input vec_t v, input int idx, input int cycles, input logic saw_req,
                                input logic [ROB_WIDTH:0] robid, input logic [PRF_WIDTH-1:0] t,
                                input logic [31:0] pc);
        check($sformatf("v%0d latency", idx), 32'(cycles), 32'(v.exp_lat));
        check($sformatf("v%0d wb_exc", idx), 32'(wb_exc), 32'(v.exp_exc));
        check($sformatf("v%0d wb_we", idx), 32'(wb_we), 32'(!v.is_write && !v.exp_exc));
        check($sformatf("v%0d wb_T", idx), 32'(wb_T), 32'(t));
        check($sformatf("v%0d wb_robid", idx), 32'(wb_robid), 32'(robid));
        check($sformatf("v%0d wb_pc", idx), wb_pc, pc);
        check($sformatf("v%0d stall_at_wb", idx), 32'(mem_issue_stall), 32'd1);
        if (v.exp_exc)
            check($sformatf("v%0d exc_no_req", idx), 32'(saw_req), 32'd0);
        else if (!v.is_write)
            check($sformatf("v%0d wb_data", idx), wb_data, v.exp_data);
    endtask

    initial begin
        int   pulses0;
        logic saw_req;

        //         w  f3      rs1           imm           rs2           rdata         exc addr          be     wdata         data          lat
        vecs[0]  = '{1'b0, F3_LW,  32'h100,      32'h4,        32'h0,        32'hDEADBEEF, 1'b0, 32'h104, 4'hF, 32'h0,        32'hDEADBEEF, 3};
        vecs[1]  = '{1'b0, F3_LB,  32'h100,      32'h3,        32'h0,        32'h80123456, 1'b0, 32'h100, 4'h8, 32'h0,        32'hFFFFFF80, 3};
        vecs[2]  = '{1'b0, F3_LBU, 32'h100,      32'h3,        32'h0,        32'h80123456, 1'b0, 32'h100, 4'h8, 32'h0,        32'h00000080, 3};
        vecs[3]  = '{1'b0, F3_LH,  32'h100,      32'h2,        32'h0,        32'h8001ABCD, 1'b0, 32'h100, 4'hC, 32'h0,        32'hFFFF8001, 3};
        vecs[4]  = '{1'b0, F3_LHU, 32'h100,      32'h2,        32'h0,        32'h8001ABCD, 1'b0, 32'h100, 4'hC, 32'h0,        32'h00008001, 3};
        vecs[5]  = '{1'b0, F3_LB,  32'h100,      32'h1,        32'h0,        32'h12345678, 1'b0, 32'h100, 4'h2, 32'h0,        32'h00000056, 3};
        vecs[6]  = '{1'b1, F3_SB,  32'h200,      32'h1,        32'h123456AB, 32'h0,        1'b0, 32'h200, 4'h2, 32'h3456AB00, 32'h0,        3};
        vecs[7]  = '{1'b1, F3_SW,  32'h300,      32'hFFFFFFFC, 32'hCAFEF00D, 32'h0,        1'b0, 32'h2FC, 4'hF, 32'hCAFEF00D, 32'h0,        3};
        vecs[8]  = '{1'b0, F3_LW,  32'hFFFFFFFC, 32'h8,        32'h0,        32'h11223344, 1'b0, 32'h004, 4'hF, 32'h0,        32'h11223344, 3};
        vecs[9]  = '{1'b0, F3_LW,  32'h100,      32'h1,        32'h0,        32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'h0,        1};
        vecs[10] = '{1'b1, F3_SH,  32'h103,      32'h0,        32'h5555,     32'h0,        1'b1, 32'h0,   4'h0, 32'h0,        32'h0,        1};

        reset_n = 1'b0; flush_valid = 1'b0; flush_robid = '0; rob_head_robid = '0;
        int2_valid = 1'b0; int2_pc = '0; int2_control = '0; int2_rs1 = '0; int2_rs2 = '0;
        int2_T = '0; int2_robid = '0;
        dmem_bus.dmem_gnt = 1'b0; dmem_bus.dmem_rvalid = 1'b0; dmem_bus.dmem_rdata = '0;
        repeat (3) @(negedge clk);
        check("reset stall", 32'(mem_issue_stall), 32'd0);
        check("reset req", 32'(dmem_bus.dmem_req), 32'd0);
        check("reset be", 32'(dmem_bus.dmem_be), 32'd0);
        check("reset addr", dmem_bus.dmem_addr, 32'd0);
        check("reset wb_valid", 32'(wb_valid), 32'd0);
        check("reset wb_robid", 32'(wb_robid), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        for (int i = 0; i < 11; i++) apply_stimulus(vecs[i], i);

        // Store waits for the head, then holds req with stable fields until gnt.
        rob_head_robid = 5'd3;
        drive_op(1'b1, F3_SH, 32'h100, 32'h2, 32'h1234, 5'd5, 6'd7, 32'h2000);
        saw_req = 1'b0;
        repeat (4) begin
            @(negedge clk);
            if (dmem_bus.dmem_req) saw_req = 1'b1;
        end
        check("sh no_req_before_head", 32'(saw_req), 32'd0);
        check("sh stall_waiting", 32'(mem_issue_stall), 32'd1);
        rob_head_robid = 5'd5;
        @(negedge clk);
        check("sh req", 32'(dmem_bus.dmem_req), 32'd1);
        check("sh be", 32'(dmem_bus.dmem_be), 32'hC);
        check("sh wdata", dmem_bus.dmem_wdata, 32'h12340000);
        @(negedge clk);
        check("sh req_held", 32'(dmem_bus.dmem_req), 32'd1);
        check("sh addr_held", dmem_bus.dmem_addr, 32'h100);
        dmem_bus.dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_bus.dmem_gnt = 1'b0;
        check("sh wb_valid", 32'(wb_valid), 32'd1);
        check("sh wb_we", 32'(wb_we), 32'd0);
        @(negedge clk);
        check("sh idle_after", 32'(mem_issue_stall), 32'd0);

        // Load killed in RSP drains its late response without writeback.
        pulses0 = wb_pulses;
        rob_head_robid = 5'd0;
        drive_op(1'b0, F3_LW, 32'h40, 32'h0, 32'h0, 5'd9, 6'd9, 32'h3000);
        @(negedge clk);
        check("drain req", 32'(dmem_bus.dmem_req), 32'd1);
        dmem_bus.dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_bus.dmem_gnt = 1'b0;
        flush_valid = 1'b1; flush_robid = 5'd7;
        @(negedge clk);
        flush_valid = 1'b0;
        check("drain stall", 32'(mem_issue_stall), 32'd1);
        repeat (2) @(negedge clk);
        dmem_bus.dmem_rvalid = 1'b1; dmem_bus.dmem_rdata = 32'hBAD0BAD0;
        @(negedge clk);
        dmem_bus.dmem_rvalid = 1'b0;
        check("drain idle", 32'(mem_issue_stall), 32'd0);
        check("drain no_wb", 32'(wb_pulses - pulses0), 32'd0);
        apply_stimulus(vecs[0], 0);

        // Wrapped robid is younger than the flush and is killed in WAIT_HEAD.
        pulses0 = wb_pulses;
        rob_head_robid = 5'd0;
        drive_op(1'b1, F3_SW, 32'h80, 32'h0, 32'h1, 5'b10010, 6'd1, 32'h4000);
        @(negedge clk);
        flush_valid = 1'b1; flush_robid = 5'b01110;
        @(negedge clk);
        flush_valid = 1'b0;
        check("wrap killed", 32'(mem_issue_stall), 32'd0);
        repeat (2) @(negedge clk);
        check("wrap no_wb", 32'(wb_pulses - pulses0), 32'd0);

        // Older op survives the flush and completes once at the head.
        drive_op(1'b1, F3_SW, 32'h80, 32'h0, 32'h1, 5'b00010, 6'd2, 32'h4004);
        @(negedge clk);
        flush_valid = 1'b1; flush_robid = 5'b00101;
        @(negedge clk);
        flush_valid = 1'b0;
        check("older survives", 32'(mem_issue_stall), 32'd1);
        rob_head_robid = 5'b00010;
        @(negedge clk);
        check("older req", 32'(dmem_bus.dmem_req), 32'd1);
        dmem_bus.dmem_gnt = 1'b1;
        @(negedge clk);
        dmem_bus.dmem_gnt = 1'b0;
        check("older wb", 32'(wb_valid), 32'd1);
        check("older wb_robid", 32'(wb_robid), 32'b00010);
        @(negedge clk);

        // Reset mid-request returns to idle with the bus quiet.
        drive_op(1'b0, F3_LW, 32'h40, 32'h0, 32'h0, 5'd1, 6'd1, 32'h5000);
        @(negedge clk);
        reset_n = 1'b0;
        @(negedge clk);
        check("midreset stall", 32'(mem_issue_stall), 32'd0);
        check("midreset req", 32'(dmem_bus.dmem_req), 32'd0);
        reset_n = 1'b1;
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
